// File: rtl/fifo_tx_scheduler_pkg.sv
// Shared definitions for the FIFO-to-transmitter scheduler: state encoding,
// the default watchdog window and a width helper for the internal timers.
package fifo_tx_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_LAUNCH    = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_GAP       = 3'd5
  } state_t;

  // Cycles allowed between tx_valid and the transmitter raising busy.
  localparam int TO_CYC_DEFAULT = 64;

  // Number of bits needed to hold values 0..max_val (never less than 1).
  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/sched_down_counter.sv
// Loadable down-counter with a zero flag. Load has priority over decrement,
// and decrementing stops at zero so the flag stays asserted once reached.
module sched_down_counter
  import fifo_tx_scheduler_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load wins, otherwise step down while not already at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register, cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/fifo_tx_scheduler.sv
// Drains the read side of an async FIFO into a serial transmitter, one word
// per frame: capture the head word, pop it, pulse tx_valid, wait for the
// transmitter's busy cycle, then insert a programmable idle gap. A watchdog
// flags a transmitter that never acknowledges, and a wrapping counter tallies
// words that completed a full busy cycle.
module fifo_tx_scheduler
  import fifo_tx_scheduler_pkg::*;
#(
  parameter int DW     = 8,
  parameter int GAP_W  = 8,
  parameter int TO_CYC = TO_CYC_DEFAULT,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             fifo_empty,
  input  logic [DW-1:0]    fifo_rd_data,
  output logic             fifo_rd_inc,
  output logic [DW-1:0]    tx_data,
  output logic             tx_valid,
  input  logic             tx_busy,
  input  logic [GAP_W-1:0] gap_cfg,
  input  logic             err_clr,
  output logic [CNT_W-1:0] word_cnt,
  output logic             timeout_err,
  output logic             sched_idle
);

  // The watchdog is loaded in LAUNCH and reaches zero on the last WAIT_BUSY
  // cycle that may still see busy rise, so timeout_err rises exactly TO_CYC
  // cycles after tx_valid. TO_CYC must be at least 2.
  localparam int              WD_W    = cnt_width(TO_CYC);
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'((TO_CYC >= 2) ? (TO_CYC - 2) : 0);

  state_t             state_q;
  state_t             state_d;
  logic [DW-1:0]      tx_data_q;
  logic [DW-1:0]      tx_data_d;
  logic               rd_inc_q;
  logic               rd_inc_d;
  logic               tx_valid_q;
  logic               tx_valid_d;
  logic               idle_q;
  logic               idle_d;
  logic               err_q;
  logic               err_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;

  logic               capture;
  logic               cnt_inc;
  logic               to_set;
  logic               wd_load;
  logic               wd_dec;
  logic               wd_zero;
  logic               gap_load;
  logic               gap_dec;
  logic               gap_zero;
  logic [GAP_W-1:0]   gap_load_val;

  // A gap of N cycles is counted N-1 down to 0. A zero gap after a timeout
  // still passes through GAP for a single cycle.
  assign gap_load_val = (gap_cfg == '0) ? '0 : (gap_cfg - GAP_W'(1));

  sched_down_counter #(
    .W (WD_W)
  ) u_watchdog (
    .clk        (clk),
    .rst        (rst),
    .load_i     (wd_load),
    .load_val_i (WD_LOAD),
    .dec_i      (wd_dec),
    .zero_o     (wd_zero)
  );

  sched_down_counter #(
    .W (GAP_W)
  ) u_gap_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (gap_load),
    .load_val_i (gap_load_val),
    .dec_i      (gap_dec),
    .zero_o     (gap_zero)
  );

  // Next-state and per-state control strobes for the word sequencer.
  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    cnt_inc  = 1'b0;
    to_set   = 1'b0;
    wd_load  = 1'b0;
    wd_dec   = 1'b0;
    gap_load = 1'b0;
    gap_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A busy transmitter may belong to another source: do not start.
        if (en && !fifo_empty && !tx_busy) begin
          capture = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_d = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        wd_load = 1'b1;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (wd_zero) begin
          to_set   = 1'b1;
          gap_load = 1'b1;
          state_d  = ST_GAP;
        end else begin
          wd_dec = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          cnt_inc = 1'b1;
          if (gap_cfg != '0) begin
            gap_load = 1'b1;
            state_d  = ST_GAP;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (gap_zero) begin
          state_d = ST_IDLE;
        end else begin
          gap_dec = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Registered outputs decoded from the next state, plus data and status.
  always_comb begin
    rd_inc_d   = (state_d == ST_LOAD);
    tx_valid_d = (state_d == ST_LAUNCH);
    idle_d     = (state_d == ST_IDLE);
    tx_data_d  = capture ? fifo_rd_data : tx_data_q;
    cnt_d      = cnt_inc ? (cnt_q + CNT_W'(1)) : cnt_q;
    // A timeout in the same cycle as err_clr leaves the flag set.
    if (to_set) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tx_data_q  <= '0;
      rd_inc_q   <= 1'b0;
      tx_valid_q <= 1'b0;
      idle_q     <= 1'b1;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      rd_inc_q   <= rd_inc_d;
      tx_valid_q <= tx_valid_d;
      idle_q     <= idle_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign fifo_rd_inc = rd_inc_q;
  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign sched_idle  = idle_q;
  assign timeout_err = err_q;
  assign word_cnt    = cnt_q;

endmodule

// File: tb/tb_fifo_tx_scheduler.sv
// Bench for fifo_tx_scheduler: a queue-backed FIFO model, a transmitter model
// that holds busy for a chosen number of cycles, directed vector tables and
// hand-written corner sequences, then randomized traffic.
module tb_fifo_tx_scheduler;

  localparam int DW     = 8;
  localparam int GAP_W  = 8;
  localparam int TO_CYC = 64;
  localparam int CNT_W  = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             fifo_empty = 1'b1;
  logic [DW-1:0]    fifo_rd_data = '0;
  logic             fifo_rd_inc;
  logic [DW-1:0]    tx_data;
  logic             tx_valid;
  logic             tx_busy;
  logic [GAP_W-1:0] gap_cfg;
  logic             err_clr;
  logic [CNT_W-1:0] word_cnt;
  logic             timeout_err;
  logic             sched_idle;

  fifo_tx_scheduler #(
    .DW     (DW),
    .GAP_W  (GAP_W),
    .TO_CYC (TO_CYC),
    .CNT_W  (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_inc  (fifo_rd_inc),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_busy      (tx_busy),
    .gap_cfg      (gap_cfg),
    .err_clr      (err_clr),
    .word_cnt     (word_cnt),
    .timeout_err  (timeout_err),
    .sched_idle   (sched_idle)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int exp_cnt = 0;

  logic [7:0] fifo_q[$];
  int  busy_len = 4;
  bit  tx_resp = 1'b1;
  bit  ext_busy = 1'b0;
  bit  mdl_busy = 1'b0;
  int  busy_left = 0;
  int  rd_pulses = 0;
  int  rd_empty_err = 0;

  assign tx_busy = mdl_busy | ext_busy;

  // FIFO and transmitter models, evaluated mid-cycle away from the DUT edge.
  always @(negedge clk) begin
    if (fifo_rd_inc === 1'b1) begin
      rd_pulses++;
      if (fifo_q.size() == 0) rd_empty_err++;
      else void'(fifo_q.pop_front());
    end
    fifo_empty   = (fifo_q.size() == 0);
    fifo_rd_data = fifo_empty ? 8'h00 : fifo_q[0];
    if (tx_valid === 1'b1 && tx_resp) begin
      mdl_busy  = 1'b1;
      busy_left = busy_len;
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) mdl_busy = 1'b0;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output bit ok);
    int n = 0;
    while (tx_valid !== 1'b1 && n < 60) begin step(); n++; end
    ok = (tx_valid === 1'b1);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (sched_idle !== 1'b1 && n < 200) begin step(); n++; end
    chk({nm, " reached_idle"}, int'(sched_idle === 1'b1), 1);
  endtask

  // One complete word: latency of rd_inc/tx_valid, data, time back to IDLE,
  // and the wrapped word count.
  task automatic xfer(input string nm, input logic [7:0] d, input bit push,
                      input int gap, input int busy, input int exp_delay);
    int n;
    gap_cfg  = GAP_W'(gap);
    busy_len = busy;
    tx_resp  = 1'b1;
    if (push) fifo_q.push_back(d);
    n = 0;
    while (fifo_rd_inc !== 1'b1 && n < 60) begin step(); n++; end
    if (fifo_rd_inc !== 1'b1) begin
      chk({nm, " rd_inc_seen"}, 0, 1);
      return;
    end
    chk({nm, " valid_before_launch"}, int'(tx_valid), 0);
    step();
    chk({nm, " tx_valid_N+2"}, int'(tx_valid), 1);
    chk({nm, " rd_inc_single"}, int'(fifo_rd_inc), 0);
    chk({nm, " tx_data"}, int'(tx_data), int'(d));
    n = 0;
    while (sched_idle !== 1'b1 && n < 200) begin step(); n++; end
    chk({nm, " valid_to_idle"}, n, exp_delay);
    exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
    chk({nm, " word_cnt"}, int'(word_cnt), exp_cnt);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, " fifo_rd_inc"}, int'(fifo_rd_inc), 0);
    chk({nm, " tx_valid"}, int'(tx_valid), 0);
    chk({nm, " tx_data"}, int'(tx_data), 0);
    chk({nm, " word_cnt"}, int'(word_cnt), 0);
    chk({nm, " timeout_err"}, int'(timeout_err), 0);
    chk({nm, " sched_idle"}, int'(sched_idle), 1);
  endtask

  typedef struct {
    logic [7:0] d;
    int         gap;
    int         busy;
    int         delay;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, tests=%0d", tests);
    $fatal(1, "bench time limit");
  end

  initial begin
    bit ok;
    int n;
    int rd_before;
    logic [7:0] mq[$];

    // delay = busy cycles + one cycle to see busy fall + gap cycles
    tbl[0] = '{8'hA5, 0, 10, 11};
    tbl[1] = '{8'h3C, 1, 2, 4};
    tbl[2] = '{8'hC3, 7, 5, 13};
    tbl[3] = '{8'h00, 0, 2, 3};
    tbl[4] = '{8'hFF, 3, 9, 13};
    tbl[5] = '{8'h5A, 2, 2, 5};

    rst = 1'b1; en = 1'b0; err_clr = 1'b0; gap_cfg = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    step();

    // Empty FIFO: enabled scheduler must never pop.
    en = 1'b1;
    repeat (10) step();
    chk("empty rd_pulses", rd_pulses, 0);
    chk("empty sched_idle", int'(sched_idle), 1);

    // Transmitter busy from another source: hold IDLE with a word waiting.
    ext_busy = 1'b1;
    fifo_q.push_back(8'h99);
    repeat (10) step();
    chk("ext_busy rd_pulses", rd_pulses, 0);
    chk("ext_busy fifo_level", fifo_q.size(), 1);
    ext_busy = 1'b0;
    xfer("ext_busy_release", 8'h99, 1'b0, 0, 2, 3);

    for (int i = 0; i < 6; i++)
      xfer($sformatf("vec%0d", i), tbl[i].d, 1'b1, tbl[i].gap, tbl[i].busy, tbl[i].delay);

    // Three queued words with a 4-cycle gap.
    fifo_q.push_back(8'h01); fifo_q.push_back(8'h02); fifo_q.push_back(8'h03);
    for (int i = 0; i < 3; i++)
      xfer($sformatf("burst%0d", i), 8'(i + 1), 1'b0, 4, 3, 8);

    // Enable drops while the first of two words is in WAIT_DONE.
    gap_cfg = '0; busy_len = 6;
    fifo_q.push_back(8'h11); fifo_q.push_back(8'h22);
    n = 0;
    while (fifo_rd_inc !== 1'b1 && n < 60) begin step(); n++; end
    chk("endrop rd_inc_seen", int'(fifo_rd_inc === 1'b1), 1);
    step();
    chk("endrop tx_data", int'(tx_data), 8'h11);
    step(); step();
    en = 1'b0;
    wait_idle("endrop");
    exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
    chk("endrop word_cnt", int'(word_cnt), exp_cnt);
    rd_before = rd_pulses;
    repeat (10) step();
    chk("endrop no_pop", rd_pulses - rd_before, 0);
    chk("endrop fifo_level", fifo_q.size(), 1);
    chk("endrop stays_idle", int'(sched_idle), 1);
    en = 1'b1;
    xfer("endrop_resume", 8'h22, 1'b0, 0, 6, 7);

    // Watchdog: transmitter never acknowledges.
    gap_cfg = '0; tx_resp = 1'b0;
    fifo_q.push_back(8'h77);
    wait_valid(ok);
    chk("timeout valid_seen", int'(ok), 1);
    n = 0;
    while (timeout_err !== 1'b1 && n < 100) begin step(); n++; end
    chk("timeout delay", n, TO_CYC);
    wait_idle("timeout");
    chk("timeout word_cnt", int'(word_cnt), exp_cnt);
    repeat (3) step();
    chk("timeout sticky", int'(timeout_err), 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("timeout err_clr", int'(timeout_err), 0);

    // err_clr held across the timeout: the set must win.
    err_clr = 1'b1;
    fifo_q.push_back(8'h78);
    wait_valid(ok);
    chk("coincide valid_seen", int'(ok), 1);
    n = 0;
    while (timeout_err !== 1'b1 && n < 100) begin step(); n++; end
    chk("coincide delay", n, TO_CYC);
    err_clr = 1'b0;
    step();
    chk("coincide set_wins", int'(timeout_err), 1);
    wait_idle("coincide");
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;

    // Asynchronous reset during WAIT_BUSY.
    tx_resp = 1'b0;
    fifo_q.push_back(8'h55);
    wait_valid(ok);
    chk("areset valid_seen", int'(ok), 1);
    step();
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("areset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_cnt = 0;
    step();
    xfer("post_reset", 8'h3C, 1'b1, 0, 3, 4);

    // 16 more words wrap the 4-bit counter to 1.
    for (int i = 0; i < 16; i++)
      xfer($sformatf("wrap%0d", i), 8'(8'h80 + i), 1'b1, 0, 2, 3);
    chk("wrap word_cnt_17", int'(word_cnt), 1);

    // Randomized traffic against an in-order queue model.
    for (int i = 0; i < 40; i++) begin
      int g;
      int b;
      logic [7:0] d;
      if (mq.size() == 0 || $urandom_range(0, 3) == 0) begin
        int k = $urandom_range(1, 3);
        for (int j = 0; j < k; j++) begin
          d = 8'($urandom);
          mq.push_back(d);
          fifo_q.push_back(d);
        end
      end
      g = $urandom_range(0, 5);
      b = $urandom_range(2, 8);
      d = mq.pop_front();
      xfer($sformatf("rand%0d", i), d, 1'b0, g, b, b + g + 1);
    end
    chk("rand fifo_level", fifo_q.size(), mq.size());

    chk("rd_inc_while_empty", rd_empty_err, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
